// File: rtl/jk_arb_pkg.sv
// Shared types and constants for the JK bank arbiter: FSM state encoding,
// JK command encodings ({j,k}) and the per-bit JK next-state helper.
package jk_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    // Per-bit command encoding, written as {j, k}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Next value of one JK flip-flop given its command and current value
    function automatic logic jk_next_bit(input logic j, input logic k, input logic q);
        logic nxt;
        case ({j, k})
            JK_HOLD: nxt = q;
            JK_SET:  nxt = 1'b1;
            JK_CLR:  nxt = 1'b0;
            JK_TGL:  nxt = ~q;
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_bank_cell.sv
// NUM_BITS-wide bank of JK flip-flops. Updates only when en is high;
// reset clears q. q_not is kept as its own register so both outputs are
// driven straight from flops.
module jk_bank_cell
    import jk_arb_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic [NUM_BITS-1:0] j,
    input  logic [NUM_BITS-1:0] k,
    output logic [NUM_BITS-1:0] q,
    output logic [NUM_BITS-1:0] q_not
);

    logic [NUM_BITS-1:0] q_r;
    logic [NUM_BITS-1:0] q_not_r;
    logic [NUM_BITS-1:0] q_next_s;

    // Per-bit JK next-state from the current command words
    always_comb begin
        q_next_s = q_r;
        for (int b = 0; b < NUM_BITS; b++) begin
            q_next_s[b] = jk_next_bit(j[b], k[b], q_r[b]);
        end
    end

    // Bank register: cleared on reset, loaded only while enabled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_r     <= {NUM_BITS{1'b0}};
            q_not_r <= {NUM_BITS{1'b1}};
        end else if (en) begin
            q_r     <= q_next_s;
            q_not_r <= ~q_next_s;
        end else begin
            q_r     <= q_r;
            q_not_r <= q_not_r;
        end
    end

    assign q     = q_r;
    assign q_not = q_not_r;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared JK bank. A grant latches the
// winner's J/K words, applies them to the bank for exactly one clock, then
// acknowledges with the updated bank state (IDLE -> APPLY -> RESP).
// Build option: JK_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no rotating pointer); undefined gives round-robin.
module jk_bank_arbiter
    import jk_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_BITS = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*NUM_BITS-1:0]   j_in,
    input  logic [NUM_REQ*NUM_BITS-1:0]   k_in,
    output logic [NUM_REQ-1:0]            ack,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [NUM_BITS-1:0]           q,
    output logic [NUM_BITS-1:0]           q_not
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ACK_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t           state_r;
    logic [IDW-1:0]       grant_id_r;
    logic [NUM_REQ-1:0]   ack_r;
    logic                 busy_r;
    logic [NUM_BITS-1:0]  cmd_j_r;
    logic [NUM_BITS-1:0]  cmd_k_r;

    logic [IDW-1:0]       winner_s;
    logic                 found_s;
    logic                 any_req_s;
    logic [NUM_BITS-1:0]  sel_j_s;
    logic [NUM_BITS-1:0]  sel_k_s;
    logic                 bank_en_s;

`ifdef JK_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downward so the lowest set index is the last writer
    always_comb begin
        winner_s = {IDW{1'b0}};
        found_s  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner_s = IDW'(i);
                found_s  = 1'b1;
            end else begin
                winner_s = winner_s;
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr_r;

    // Round-robin: first set request at or after rr_ptr, wrapping upward
    always_comb begin
        winner_s = {IDW{1'b0}};
        found_s  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_s && req[(int'(rr_ptr_r) + i) % NUM_REQ]) begin
                winner_s = IDW'((int'(rr_ptr_r) + i) % NUM_REQ);
                found_s  = 1'b1;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Pointer moves to one past the winner on each grant
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= {IDW{1'b0}};
        end else if (state_r == IDLE && any_req_s) begin
            rr_ptr_r <= IDW'((int'(winner_s) + 1) % NUM_REQ);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    assign any_req_s = |req;
    assign sel_j_s   = j_in[int'(winner_s) * NUM_BITS +: NUM_BITS];
    assign sel_k_s   = k_in[int'(winner_s) * NUM_BITS +: NUM_BITS];
    assign bank_en_s = (state_r == APPLY);

    // Transaction FSM: grant in IDLE, apply for one clock, acknowledge in RESP
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            grant_id_r <= {IDW{1'b0}};
            ack_r      <= {NUM_REQ{1'b0}};
            busy_r     <= 1'b0;
            cmd_j_r    <= {NUM_BITS{1'b0}};
            cmd_k_r    <= {NUM_BITS{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r <= {NUM_REQ{1'b0}};
                    if (any_req_s) begin
                        cmd_j_r    <= sel_j_s;
                        cmd_k_r    <= sel_k_s;
                        grant_id_r <= winner_s;
                        busy_r     <= 1'b1;
                        state_r    <= APPLY;
                    end else begin
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                APPLY: begin
                    ack_r   <= ACK_ONE << grant_id_r;
                    busy_r  <= 1'b1;
                    state_r <= RESP;
                end
                RESP: begin
                    ack_r   <= {NUM_REQ{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    ack_r   <= {NUM_REQ{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    jk_bank_cell #(
        .NUM_BITS (NUM_BITS)
    ) u_bank (
        .clock (clock),
        .reset (reset),
        .en    (bank_en_s),
        .j     (cmd_j_r),
        .k     (cmd_k_r),
        .q     (q),
        .q_not (q_not)
    );

    assign ack      = ack_r;
    assign grant_id = grant_id_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: drivers push expected {requester,
// bank value, ack cycle} entries; a monitor pops one per ack and compares.
module tb_jk_bank_arbiter;

    localparam int NR = 4;
    localparam int NB = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req   = '0;
    logic [NR*NB-1:0]  j_in  = '0;
    logic [NR*NB-1:0]  k_in  = '0;
    logic [NR-1:0]     ack;
    logic [1:0]        grant_id;
    logic              busy;
    logic [NB-1:0]     q;
    logic [NB-1:0]     q_not;

    typedef struct {
        int         id;
        logic [7:0] qv;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    jk_bank_arbiter #(.NUM_REQ(NR), .NUM_BITS(NB)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .j_in     (j_in),
        .k_in     (k_in),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy),
        .q        (q),
        .q_not    (q_not)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on every ack
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (!reset) begin
            chk("q_not_inv", {24'd0, q_not}, {24'd0, ~q});
            chk("ack_onehot0", {31'd0, $onehot0(ack)}, 32'd1);
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {28'd0, ack}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_vec", {28'd0, ack}, 32'd1 << e.id);
                    chk("ack_grant_id", {30'd0, grant_id}, e.id);
                    chk("ack_q", {24'd0, q}, {24'd0, e.qv});
                    chk("ack_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_q"}, {24'd0, q}, 32'h00);
        chk({tag, "_q_not"}, {24'd0, q_not}, 32'hFF);
        chk({tag, "_ack"}, {28'd0, ack}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_grant_id"}, {30'd0, grant_id}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req   = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_reset_state("rst");
    endtask

    // Wait (bounded) until count acks have been seen, then drop all req
    task automatic wait_acks(input int count, input string nm);
        int seen = 0;
        for (int t = 0; t < 60 && seen < count; t++) begin
            @(negedge clock);
            if (ack != '0) seen++;
        end
        req = '0;
        chk({nm, "_acks_seen"}, seen, count);
    endtask

    // One single-requester transaction; optionally alter the words in APPLY
    task automatic txn(input int r, input logic [7:0] j, input logic [7:0] k,
                       input logic [7:0] q_exp, input bit chg);
        exp_t e;
        @(negedge clock);
        j_in[r*NB +: NB] = j;
        k_in[r*NB +: NB] = k;
        req[r] = 1'b1;
        e.id = r; e.qv = q_exp; e.cyc = cyc + 2;
        sb.push_back(e);
        @(negedge clock);
        chk("apply_busy", {31'd0, busy}, 32'd1);
        chk("apply_grant_id", {30'd0, grant_id}, r);
        chk("apply_no_ack", {28'd0, ack}, 32'd0);
        if (chg) begin
            j_in[r*NB +: NB] = 8'hFF;
            k_in[r*NB +: NB] = 8'h00;
        end
        wait_acks(1, "txn");
    endtask

    typedef struct {
        int         id;
        logic [7:0] qv;
    } vec_t;

    initial begin
        exp_t e;
        int   base;
        vec_t held[5];
        vec_t alt[2];

        // Reset, then idle
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check_reset_state("idle");

        // Requester 1 alone: set, clear, toggle
        txn(1, 8'h0F, 8'h00, 8'h0F, 1'b0);
        txn(1, 8'h00, 8'h05, 8'h0A, 1'b0);
        txn(1, 8'hFF, 8'hFF, 8'hF5, 1'b0);

        // All four requesting continuously
        do_reset();
`ifdef JK_ARB_FIXED_PRIO_EN
        held = '{'{0, 8'h01}, '{0, 8'h01}, '{0, 8'h01}, '{0, 8'h01}, '{0, 8'h01}};
        alt  = '{'{1, 8'h00}, '{1, 8'h00}};
`else
        held = '{'{0, 8'h01}, '{1, 8'h03}, '{2, 8'h02}, '{3, 8'hF2}, '{0, 8'hF3}};
        alt  = '{'{1, 8'h00}, '{3, 8'hF0}};
`endif
        @(negedge clock);
        j_in = {8'hF0, 8'h00, 8'h02, 8'h01};
        k_in = {8'h00, 8'h01, 8'h00, 8'h00};
        req  = 4'b1111;
        base = cyc;
        for (int i = 0; i < 5; i++) begin
            e.id = held[i].id; e.qv = held[i].qv; e.cyc = base + 2 + 3 * i;
            sb.push_back(e);
        end
        wait_acks(5, "held");

        // Requesters 1 and 3 only
        @(negedge clock);
        j_in = {8'hF0, 8'h00, 8'h00, 8'h00};
        k_in = {8'h00, 8'h00, 8'hFF, 8'h00};
        req  = 4'b1010;
        base = cyc;
        for (int i = 0; i < 2; i++) begin
            e.id = alt[i].id; e.qv = alt[i].qv; e.cyc = base + 2 + 3 * i;
            sb.push_back(e);
        end
        wait_acks(2, "alt");

        // Words changed after grant must not affect the transaction
        do_reset();
        txn(2, 8'h3C, 8'h00, 8'h3C, 1'b1);

        // Reset during APPLY aborts: no ack, bank cleared
        @(negedge clock);
        j_in[0 +: NB] = 8'hFF;
        k_in[0 +: NB] = 8'hFF;
        req[0] = 1'b1;
        @(negedge clock);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_reset_state("abort");
        req = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_reset_state("post_abort");
        txn(3, 8'h81, 8'h00, 8'h81, 1'b0);

        // Toggle stress on requester 0
        do_reset();
        txn(0, 8'hAA, 8'hAA, 8'hAA, 1'b0);
        txn(0, 8'hAA, 8'hAA, 8'h00, 1'b0);
        txn(0, 8'hAA, 8'hAA, 8'hAA, 1'b0);
        txn(0, 8'hAA, 8'hAA, 8'h00, 1'b0);

        repeat (5) @(negedge clock);
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
